// File: rtl/trace_buffer_trig.sv
// trace_buffer_trig: triggered circular trace buffer with streaming readout.
//
// Captures N-lane vectors while armed. Capture freezes on a trigger plus a
// programmable post-trigger window, when tracing drops, or when the buffer is full
// in stop-when-full mode. The frozen contents are then dumped oldest-first over a
// valid/ready stream.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   tracing_i            arm / capture enable (level)
//   valid_in_i           vector_in_i beat valid (no backpressure)
//   vector_in_i          captured vector, lane 0 in the low bits
//   trigger_i            trigger pulse
//   mode_i               0 = wrap, 1 = stop-when-full (sampled on arming)
//   post_count_i         beats captured after the trigger beat (sampled on arming)
//   dump_start_i         readout request pulse (honoured only when frozen)
//   out_valid_o          vector_out_o valid
//   out_ready_i          downstream accept
//   vector_out_o         dumped vector
//   out_last_o           final dumped beat
//   occupancy_o          stored entries
//   triggered_o          trigger seen during this capture
//   wrapped_o            oldest data overwritten during this capture
//   done_o               capture frozen
module trace_buffer_trig #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TB_SIZE    = 64,
  localparam int unsigned CW        = $clog2(TB_SIZE + 1),
  localparam int unsigned AW        = $clog2(TB_SIZE)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           tracing_i,
  input  logic                           valid_in_i,
  input  logic [N-1:0][DATA_WIDTH-1:0]   vector_in_i,
  input  logic                           trigger_i,
  input  logic                           mode_i,
  input  logic [CW-1:0]                  post_count_i,
  input  logic                           dump_start_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [N-1:0][DATA_WIDTH-1:0]   vector_out_o,
  output logic                           out_last_o,
  output logic [CW-1:0]                  occupancy_o,
  output logic                           triggered_o,
  output logic                           wrapped_o,
  output logic                           done_o
);

  typedef enum logic [2:0] {StIdle, StArmed, StPost, StFrozen, StDump} state_e;
  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
  typedef struct packed {
    vec_t data;
    logic last;
  } entry_t;

  localparam logic [CW-1:0] Full = CW'(TB_SIZE);
  localparam logic [CW-1:0] One  = CW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] post_q, post_d;
  logic [CW-1:0] remain_q, remain_d;
  logic [CW-1:0] rd_left_q, rd_left_d;
  logic          mode_q, mode_d;
  logic          trig_q, trig_d;
  logic          wrap_q, wrap_d;

  vec_t          mem_q [TB_SIZE];

  logic          capturing, full, drop, wr_en;

  // Readout path: registered memory read, then a 2-entry skid buffer.
  logic          rd_issue;
  logic          rd_vld_q;
  logic          rd_last_q;
  vec_t          rd_data_q;
  entry_t        skid_q [2];
  entry_t        skid_d [2];
  logic [1:0]    skid_cnt_q, skid_cnt_d;
  logic          pop, push, last_done;
  logic [2:0]    inflight;

  assign capturing = (state_q == StArmed) || (state_q == StPost);
  assign full      = (occ_q == Full);
  // In stop-when-full mode a beat arriving at a full buffer is discarded.
  assign drop      = capturing && valid_in_i && mode_q && full;
  assign wr_en     = capturing && valid_in_i && !drop;

  assign out_valid_o = (skid_cnt_q != 2'd0);
  assign pop         = out_valid_o && out_ready_i;
  assign push        = rd_vld_q;
  assign last_done   = pop && skid_q[0].last;

  // Beats that will occupy the skid after this edge if no new read is issued;
  // issuing only below 2 guarantees a pushed beat always finds a free slot.
  assign inflight = {1'b0, skid_cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign rd_issue = (state_q == StDump) && (rd_left_q != '0) && (inflight < 3'd2);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    post_d    = post_q;
    remain_d  = remain_q;
    rd_left_d = rd_left_q;
    mode_d    = mode_q;
    trig_d    = trig_q;
    wrap_d    = wrap_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (full) begin
        wrap_d = 1'b1;
      end else begin
        occ_d = occ_q + One;
      end
    end

    if (rd_issue) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_left_d = rd_left_q - One;
    end

    unique case (state_q)
      StIdle: begin
        if (tracing_i) begin
          state_d  = StArmed;
          wr_ptr_d = '0;
          occ_d    = '0;
          trig_d   = 1'b0;
          wrap_d   = 1'b0;
          mode_d   = mode_i;
          post_d   = post_count_i;
        end
      end
      StArmed: begin
        if (trigger_i) begin
          trig_d = 1'b1;
          if (post_q == '0) begin
            state_d = StFrozen;
          end else begin
            state_d  = StPost;
            remain_d = post_q;
          end
        end
        if (!tracing_i || drop) begin
          state_d = StFrozen;
        end
      end
      StPost: begin
        if (wr_en) begin
          remain_d = remain_q - One;
          if (remain_q == One) begin
            state_d = StFrozen;
          end
        end
        if (!tracing_i || drop) begin
          state_d = StFrozen;
        end
      end
      StFrozen: begin
        if (dump_start_i) begin
          if (occ_q != '0) begin
            state_d   = StDump;
            // Truncation to AW bits gives the oldest slot, including when full.
            rd_ptr_d  = wr_ptr_q - occ_q[AW-1:0];
            rd_left_d = occ_q;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDump: begin
        if (last_done) begin
          state_d = StIdle;
          occ_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      post_q    <= '0;
      remain_q  <= '0;
      rd_left_q <= '0;
      mode_q    <= 1'b0;
      trig_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      post_q    <= post_d;
      remain_q  <= remain_d;
      rd_left_q <= rd_left_d;
      mode_q    <= mode_d;
      trig_q    <= trig_d;
      wrap_q    <= wrap_d;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= vector_in_i;
    end
  end

  always_comb begin
    skid_d     = skid_q;
    skid_cnt_d = skid_cnt_q;
    unique case ({push, pop})
      2'b10: begin
        skid_d[skid_cnt_q[0]] = '{data: rd_data_q, last: rd_last_q};
        skid_cnt_d            = skid_cnt_q + 2'd1;
      end
      2'b01: begin
        skid_d[0]  = skid_q[1];
        skid_cnt_d = skid_cnt_q - 2'd1;
      end
      2'b11: begin
        if (skid_cnt_q == 2'd1) begin
          skid_d[0] = '{data: rd_data_q, last: rd_last_q};
        end else begin
          skid_d[0] = skid_q[1];
          skid_d[1] = '{data: rd_data_q, last: rd_last_q};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      skid_cnt_q <= 2'd0;
    end else begin
      rd_vld_q <= rd_issue;
      if (rd_issue) begin
        rd_data_q <= mem_q[rd_ptr_q];
        rd_last_q <= (rd_left_q == One);
      end
      skid_q[0]  <= skid_d[0];
      skid_q[1]  <= skid_d[1];
      skid_cnt_q <= skid_cnt_d;
    end
  end

  assign vector_out_o = skid_q[0].data;
  assign out_last_o   = out_valid_o && skid_q[0].last;
  assign occupancy_o  = occ_q;
  assign triggered_o  = trig_q;
  assign wrapped_o    = wrap_q;
  assign done_o       = (state_q == StFrozen);

endmodule

// File: doc/trace_buffer_trig.md
# trace_buffer_trig

Triggered, parametrised circular trace buffer with streaming readout. Captures N-lane vectors from the debug datapath while armed, freezes on trigger plus a programmable post-trigger window or on full, then dumps contents oldest-first over a valid/ready stream to the host readout path. Sits at the tail of the filter/reduce chain in place of the fixed write-only buffer.

## Interface
- N, 8, lanes per vector
- DATA_WIDTH, 32, bits per lane
- TB_SIZE, 64, entries; power of two, ≥4
- CW (localparam), $clog2(TB_SIZE+1), counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tracing  in  1  arm/capture enable (level)
- valid_in  in  1  vector_in beat valid
- vector_in  in  [DATA_WIDTH-1:0] x N  captured vector
- trigger  in  1  trigger pulse, sampled each cycle
- mode  in  1  0 = wrap (overwrite oldest), 1 = stop-when-full; sampled on arming
- post_count  in  CW  beats captured after trigger beat; sampled on arming, ≤ TB_SIZE
- dump_start  in  1  request readout (pulse)
- out_valid  out  1  vector_out valid
- out_ready  in  1  downstream accepts
- vector_out  out  [DATA_WIDTH-1:0] x N  dumped vector
- out_last  out  1  qualifies final dumped beat
- occupancy  out  CW  stored entries
- triggered  out  1  trigger seen this capture
- wrapped  out  1  oldest data overwritten this capture
- done  out  1  state FROZEN

## Operation
- States: IDLE, ARMED, POST, FROZEN, DUMP. Reset → IDLE.
- IDLE: no writes. tracing=1 → ARMED; wr_ptr, occupancy, triggered, wrapped cleared; mode, post_count latched.
- ARMED/POST write: valid_in=1 writes vector_in at wr_ptr; wr_ptr+1 mod TB_SIZE; occupancy saturates at TB_SIZE; write at occupancy==TB_SIZE sets wrapped.
- mode=1: beat arriving at occupancy==TB_SIZE dropped, state → FROZEN.
- ARMED + trigger: triggered=1; same-cycle valid beat written (trigger beat, not counted in post window). post_count==0 → FROZEN, else → POST with remaining=post_count.
- POST: each written beat decrements remaining; write that reaches 0 → FROZEN. trigger ignored.
- tracing=0 in ARMED/POST → FROZEN same edge; same-cycle valid beat still written.
- FROZEN: done=1, no writes. dump_start with occupancy>0 → DUMP, rd_ptr=(wr_ptr−occupancy) mod TB_SIZE; with occupancy==0 → IDLE.
- DUMP: streams occupancy beats oldest→newest; out_last=1 on final beat; on its handshake → IDLE, occupancy cleared. triggered/wrapped hold until next arm.
- dump_start outside FROZEN, tracing/trigger/valid_in outside ARMED/POST: ignored.
- Lane order: lane 0 of vector_in appears on lane 0 of vector_out.

## Timing
- Reset (async assert, sync-free release): all outputs 0, state IDLE, pointers 0. Memory contents not reset.
- Capture: write committed at the clk edge where valid_in=1; no backpressure on input.
- Memory read latency 1 cycle (registered); output stage is a 2-entry skid so stream sustains 1 beat/cycle with out_ready held high.
- First out_valid 2 cycles after the edge accepting dump_start; transfer on out_valid&&out_ready.
- out_valid high with out_ready low: vector_out, out_last held stable; no beat lost or duplicated.
- out_valid never deasserts mid-dump without a handshake.
- Reset mid-DUMP: out_valid drops asynchronously; buffer contents lost logically (occupancy 0).
- Status (occupancy, triggered, wrapped, done) registered, update the edge after the causing event.

## Test plan
- N=4, DW=8, TB_SIZE=8, mode=0: arm, 5 beats 0..4, tracing=0, dump with out_ready=1 → 5 beats 0..4 on consecutive cycles, out_last on 4, occupancy 5 then 0, wrapped=0.
- mode=0, 11 beats 0..10, trigger on beat 6, post_count=2 → FROZEN after beat 8; dump yields 1..8, wrapped=1, triggered=1.
- mode=1, 10 beats 0..9 no trigger → FROZEN after beat 7 (beat 8 dropped), occupancy 8; dump yields 0..7.
- Dump with out_ready toggling 1,0,0,1,0,1… → every beat appears exactly once in order, data stable during stalls.
- trigger with post_count=0 on beat 3 of 0..5 → freeze at beat 3, dump 0..3; dump_start in ARMED ignored; dump_start at occupancy 0 → IDLE, no out_valid.
- rst_n low mid-DUMP after 2 beats → out_valid 0 immediately, state IDLE, occupancy 0; re-arm works normally.
